// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_ctrl_pkg
//  Description : Shared types and constants for the toy_cpu pipeline
//                stall/flush controller: stage indices, hold/no-hold
//                encodings, FSM state type and a counter-width helper.
//  Revision    : 1.0  initial release
// ============================================================================
package pipe_hazard_ctrl_pkg;

  // Hold encodings on the stall bus
  localparam logic STOP   = 1'b1;
  localparam logic NOSTOP = 1'b0;

  // Default stage indices (stallreq bit positions)
  localparam int STAGE_IF  = 0;
  localparam int STAGE_ID  = 1;
  localparam int STAGE_EX  = 2;
  localparam int STAGE_MEM = 3;
  localparam int STAGE_WB  = 4;

  // Sequencer states
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  // Stall bus carries the PC hold plus one hold per stage
  function automatic int stall_bus_w(input int nstage);
    return nstage + 1;
  endfunction

  // Width needed to hold values 0..n-1, never less than one bit
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : pipe_hazard_ctrl_pkg
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_stall_enc.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_ctrl_stall_enc
//  Description : Priority encoder from per-stage stall requests to a
//                thermometer hold vector. The highest requesting stage k
//                holds itself, every earlier stage and the PC.
//  Ports       : i_stallreq [NSTAGE-1:0] per-stage stall requests
//                o_stall    [NSTAGE:0]   bit0 = PC hold, bit j+1 = stage j
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_hazard_ctrl_stall_enc
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int NSTAGE = 5
) (
  input  logic [NSTAGE-1:0] i_stallreq,
  output logic [NSTAGE:0]   o_stall
);

  logic w_any;

  // Running OR from the last stage downward: stage j holds iff some
  // stage at index >= j requests a stall.
  always_comb begin
    w_any   = NOSTOP;
    o_stall = '0;
    for (int j = NSTAGE - 1; j >= 0; j--) begin
      w_any        = w_any | i_stallreq[j];
      o_stall[j+1] = w_any;
    end
    o_stall[0] = w_any;
  end

endmodule : pipe_hazard_ctrl_stall_enc
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_ctrl
//  Description : Pipeline stall/flush controller. Combinational thermometer
//                stall bus, registered flush sequencer with redirect PC,
//                saturating stall-cycle counter and sticky stall watchdog.
//  Ports       : clk, rst        clock / synchronous active-high reset
//                i_stallreq      per-stage stall requests
//                i_flush_req     one-cycle redirect request
//                i_flush_pc      redirect target, sampled with i_flush_req
//                i_cnt_clr       clears o_stall_cnt
//                o_stall         PC + per-stage hold bus
//                o_flush         clear pipeline registers, load o_new_pc
//                o_new_pc        redirect target
//                o_stall_cnt     saturating count of stalled cycles
//                o_wdog_err      sticky stall-watchdog error
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int NSTAGE     = 5,
  parameter int ADDR_W     = 32,
  parameter int FLUSH_CYC  = 1,
  parameter int CNT_W      = 16,
  parameter int WDOG_LIMIT = 1023
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NSTAGE-1:0]   i_stallreq,
  input  logic                i_flush_req,
  input  logic [ADDR_W-1:0]   i_flush_pc,
  input  logic                i_cnt_clr,
  output logic [NSTAGE:0]     o_stall,
  output logic                o_flush,
  output logic [ADDR_W-1:0]   o_new_pc,
  output logic [CNT_W-1:0]    o_stall_cnt,
  output logic                o_wdog_err
);

  localparam int                FC_W          = cnt_width(FLUSH_CYC);
  localparam logic [FC_W-1:0]   c_fcnt_load   = FC_W'(FLUSH_CYC - 1);
  localparam logic [CNT_W-1:0]  c_wdog_limit  = CNT_W'(WDOG_LIMIT);
  localparam logic [CNT_W-1:0]  c_wdog_arm    = CNT_W'(WDOG_LIMIT - 1);
  localparam logic [CNT_W-1:0]  c_cnt_max     = '1;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [FC_W-1:0]     r_fcnt;
  logic [FC_W-1:0]     w_fcnt_nxt;
  logic                w_latch;
  logic                w_entry;
  logic [NSTAGE:0]     w_therm;
  logic                w_stalled;
  logic [ADDR_W-1:0]   r_new_pc;
  logic [CNT_W-1:0]    r_stall_cnt;
  logic [CNT_W-1:0]    r_consec;
  logic                r_wdog_err;

  pipe_hazard_ctrl_stall_enc #(
    .NSTAGE     (NSTAGE)
  ) u_stall_enc (
    .i_stallreq (i_stallreq),
    .o_stall    (w_therm)
  );

  // While flushing, the pipeline is being cleared, so holds are meaningless.
  assign o_stall   = (rst || (r_state == ST_FLUSH)) ? '0 : w_therm;
  assign w_stalled = |o_stall;

  assign o_flush     = (r_state == ST_FLUSH);
  assign o_new_pc    = r_new_pc;
  assign o_stall_cnt = r_stall_cnt;
  assign o_wdog_err  = r_wdog_err;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_fcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_fcnt  <= w_fcnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_fcnt_nxt  = r_fcnt;
    w_latch     = 1'b0;
    w_entry     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_flush_req) begin
          w_state_nxt = ST_FLUSH;
          w_fcnt_nxt  = c_fcnt_load;
          w_latch     = 1'b1;
          w_entry     = 1'b1;
        end
      end
      ST_FLUSH: begin
        // A newer redirect replaces the pending one and restarts the count.
        if (i_flush_req) begin
          w_fcnt_nxt = c_fcnt_load;
          w_latch    = 1'b1;
        end else if (r_fcnt == '0) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_fcnt_nxt = r_fcnt - 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------- redirect PC
  always_ff @(posedge clk) begin
    if (rst) begin
      r_new_pc <= '0;
    end else if (w_latch) begin
      r_new_pc <= i_flush_pc;
    end
  end

  // ------------------------------------------------------ stall counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (i_cnt_clr) begin
      r_stall_cnt <= '0;
    end else if (w_stalled && (r_stall_cnt != c_cnt_max)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  // ------------------------------------------------------------ watchdog
  always_ff @(posedge clk) begin
    if (rst) begin
      r_consec <= '0;
    end else if (!w_stalled) begin
      r_consec <= '0;
    end else if (r_consec != c_wdog_limit) begin
      r_consec <= r_consec + 1'b1;
    end
  end

  // The error fires on the edge that completes the LIMIT-th stalled cycle.
  // A flush entry is a recovery action, so it takes priority over setting.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wdog_err <= 1'b0;
    end else if (w_entry) begin
      r_wdog_err <= 1'b0;
    end else if (w_stalled && (r_consec >= c_wdog_arm)) begin
      r_wdog_err <= 1'b1;
    end
  end

endmodule : pipe_hazard_ctrl
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_hazard_ctrl
//  Description : Self-checking bench for pipe_hazard_ctrl with directed
//                sequences followed by randomized traffic, compared against
//                a cycle-level behavioural model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

  localparam int NSTAGE     = 5;
  localparam int ADDR_W     = 32;
  localparam int FLUSH_CYC  = 3;
  localparam int CNT_W      = 4;
  localparam int WDOG_LIMIT = 8;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  logic                clk;
  logic                rst;
  logic [NSTAGE-1:0]   i_stallreq;
  logic                i_flush_req;
  logic [ADDR_W-1:0]   i_flush_pc;
  logic                i_cnt_clr;
  logic [NSTAGE:0]     o_stall;
  logic                o_flush;
  logic [ADDR_W-1:0]   o_new_pc;
  logic [CNT_W-1:0]    o_stall_cnt;
  logic                o_wdog_err;

  pipe_hazard_ctrl #(
    .NSTAGE      (NSTAGE),
    .ADDR_W      (ADDR_W),
    .FLUSH_CYC   (FLUSH_CYC),
    .CNT_W       (CNT_W),
    .WDOG_LIMIT  (WDOG_LIMIT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_stallreq  (i_stallreq),
    .i_flush_req (i_flush_req),
    .i_flush_pc  (i_flush_pc),
    .i_cnt_clr   (i_cnt_clr),
    .o_stall     (o_stall),
    .o_flush     (o_flush),
    .o_new_pc    (o_new_pc),
    .o_stall_cnt (o_stall_cnt),
    .o_wdog_err  (o_wdog_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ------------------------------------------------ behavioural model
  int          m_flush_left;   // cycles of flush still to be shown
  logic [31:0] m_pc;
  int          m_cnt;
  int          m_consec;
  bit          m_err;

  function automatic logic [NSTAGE:0] model_stall(input bit rs, input logic [NSTAGE-1:0] rq);
    int top;
    top = -1;
    for (int k = 0; k < NSTAGE; k++) if (rq[k]) top = k;
    if (rs || m_flush_left > 0 || top < 0) return '0;
    return (NSTAGE+1)'((1 << (top + 2)) - 1);
  endfunction

  task automatic step(input bit rs, input logic [NSTAGE-1:0] rq, input bit fr,
                      input logic [31:0] pc, input bit cl, input bit en);
    logic [NSTAGE:0] es;
    bit stalled;
    bit entry;
    @(negedge clk);
    rst = rs; i_stallreq = rq; i_flush_req = fr; i_flush_pc = pc; i_cnt_clr = cl;
    #1;
    es = model_stall(rs, rq);
    if (en) begin
      check("stall",     64'(o_stall),     64'(es));
      check("flush",     64'(o_flush),     64'(m_flush_left > 0));
      check("new_pc",    64'(o_new_pc),    64'(m_pc));
      check("stall_cnt", 64'(o_stall_cnt), 64'(m_cnt));
      check("wdog_err",  64'(o_wdog_err),  64'(m_err));
    end
    @(posedge clk);
    stalled = (es != '0);
    if (rs) begin
      m_flush_left = 0; m_pc = '0; m_cnt = 0; m_consec = 0; m_err = 1'b0;
    end else begin
      entry = fr && (m_flush_left == 0);
      if (fr) begin
        m_flush_left = FLUSH_CYC;
        m_pc = pc;
      end else if (m_flush_left > 0) begin
        m_flush_left--;
      end
      if (cl) m_cnt = 0;
      else if (stalled && m_cnt < CNT_MAX) m_cnt++;
      m_consec = stalled ? ((m_consec < WDOG_LIMIT) ? m_consec + 1 : WDOG_LIMIT) : 0;
      if (entry) m_err = 1'b0;
      else if (stalled && m_consec >= WDOG_LIMIT) m_err = 1'b1;
    end
  endtask

  initial begin
    bit quiet;
    rst = 1'b1; i_stallreq = '0; i_flush_req = 1'b0; i_flush_pc = '0; i_cnt_clr = 1'b0;
    m_flush_left = 0; m_pc = '0; m_cnt = 0; m_consec = 0; m_err = 1'b0;

    // Reset with random requests: outputs quiet
    step(1'b1, NSTAGE'($urandom), 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b1, NSTAGE'($urandom), 1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b1, NSTAGE'($urandom), 1'b0, 32'h0, 1'b0, 1'b1);

    // Thermometer encoding, highest stage wins
    step(1'b0, 5'b00100, 1'b0, 32'h0, 1'b0, 1'b1);
    check("stall_ex", 64'(o_stall), 64'(6'b001111));
    step(1'b0, 5'b00010, 1'b0, 32'h0, 1'b0, 1'b1);
    check("stall_id", 64'(o_stall), 64'(6'b000111));
    step(1'b0, 5'b10110, 1'b0, 32'h0, 1'b0, 1'b1);
    check("stall_multi", 64'(o_stall), 64'(6'b111111));
    step(1'b0, 5'b00000, 1'b0, 32'h0, 1'b0, 1'b1);

    // Flush with stall held, then a second flush mid-sequence
    step(1'b0, 5'b00100, 1'b1, 32'h40, 1'b0, 1'b1);   // t
    step(1'b0, 5'b00100, 1'b0, 32'h0,  1'b0, 1'b1);   // t+1
    check("flush_t1", 64'(o_flush), 64'd1);
    step(1'b0, 5'b00100, 1'b1, 32'h80, 1'b0, 1'b1);   // t+2
    check("pc_t2", 64'(o_new_pc), 64'h40);
    for (int i = 0; i < 5; i++) step(1'b0, 5'b00100, 1'b0, 32'h0, 1'b0, 1'b1);
    check("stall_after", 64'(o_stall), 64'(6'b001111));

    // Single flush without interference
    step(1'b0, 5'b00100, 1'b1, 32'h40, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 5'b00100, 1'b0, 32'h0, 1'b0, 1'b1);

    // Watchdog: drop stall, then hold IF stall long enough, then flush clears
    step(1'b0, 5'b00000, 1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) step(1'b0, 5'b00001, 1'b0, 32'h0, 1'b0, 1'b1);
    check("wdog_set", 64'(o_wdog_err), 64'd1);
    step(1'b0, 5'b00000, 1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 5'b00000, 1'b1, 32'h100, 1'b0, 1'b1);
    step(1'b0, 5'b00000, 1'b0, 32'h0, 1'b0, 1'b1);
    check("wdog_clr", 64'(o_wdog_err), 64'd0);
    for (int i = 0; i < 4; i++) step(1'b0, 5'b00000, 1'b0, 32'h0, 1'b0, 1'b1);

    // Counter saturation and clear while stalled
    for (int i = 0; i < 20; i++) step(1'b0, 5'b01000, 1'b0, 32'h0, 1'b0, 1'b1);
    check("cnt_sat", 64'(o_stall_cnt), 64'd15);
    step(1'b0, 5'b01000, 1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b0, 5'b00000, 1'b0, 32'h0, 1'b0, 1'b1);
    check("cnt_clr", 64'(o_stall_cnt), 64'd0);

    // Randomized traffic with long stall bursts and occasional resets
    quiet = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      bit rs, fr, cl;
      logic [NSTAGE-1:0] rq;
      if ($urandom_range(0, 23) == 0) quiet = !quiet;
      rq = quiet ? NSTAGE'(($urandom_range(0, 7) == 0) ? $urandom : 0)
                 : NSTAGE'($urandom_range(1, 31));
      rs = ($urandom_range(0, 99) == 0);
      fr = quiet ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 39) == 0);
      cl = ($urandom_range(0, 29) == 0);
      step(rs, rq, fr, $urandom, cl, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_pipe_hazard_ctrl
`default_nettype wire
